vdp_map_fetch_scheduler: RTL and testbench
==========================================

# vdp_map_fetch_scheduler

Per-raster-line sequencer for the VDP tilemap fetch path. On each line-start strobe it walks every enabled layer across a fixed number of coarse (8-pixel) columns. For each (layer, column) pair it computes the map-entry VRAM address and issues a read over a ready/valid request port. Returned VRAM words are tagged with layer and column so the tile/pattern fetch stage downstream can consume them.

## Interface
Parameters:
- LAYERS, 4: number of map layers; layer index width is $clog2(LAYERS).
- COLUMNS, 64: coarse columns fetched per line; legal range 1..128.
- READ_LATENCY, 2: fixed cycles from an accepted VRAM request to valid vram_read_data; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle strobe that starts a line's fetch.
- raster_y  in  10  line being prepared.
- layer_enable  in  LAYERS  per-layer fetch enable.
- scroll_y  in  10*LAYERS  layer l at [10l+9:10l].
- scroll_x_coarse  in  7*LAYERS  layer l at [7l+6:7l].
- map_base_address  in  15*LAYERS  16-bit-word address, layer l at [15l+14:15l].
- stride  in  8*LAYERS  layer l at [8l+7:8l]; only bit 7 (128-wide map) is used.
- vram_read_req  out  1  request valid.
- vram_address  out  15  request word address.
- vram_read_ready  in  1  request accepted when high with vram_read_req.
- vram_read_data  in  16  read data, valid READ_LATENCY cycles after acceptance.
- map_data  out  16  vram_read_data passthrough.
- map_data_valid  out  1  map_data holds a returned map entry.
- map_data_layer  out  $clog2(LAYERS)  layer tag of map_data.
- map_data_column  out  7  raster coarse column tag (0..COLUMNS-1).
- busy  out  1  line fetch in progress.
- line_done  out  1  one-cycle pulse when the line is complete.
- overrun  out  1  one-cycle pulse when line_start arrives while busy.

## Operation
- States:
  - IDLE, FETCH and DRAIN.
  - IDLE + line_start: snapshot raster_y and all per-layer configuration into internal registers; input changes after this have no effect until the next line.
  - From IDLE: go to FETCH with column=0 and layer=lowest enabled layer. If no layer is enabled, go to DRAIN with an empty pipeline.
- FETCH order:
  - Column-major: for each column 0..COLUMNS-1, every enabled layer in ascending index order.
  - Disabled layers are skipped with no bubble cycle.
- Request rules:
  - A request is accepted when vram_read_req && vram_read_ready.
  - vram_read_req, vram_address and the internal tag are held stable while ready is low.
  - After acceptance, the next pair is presented in the following cycle.
  - After the final pair is accepted, go to DRAIN.
- Address for layer l, column c (all wraps modulo field width):
  - col7 = scroll_x_coarse + c (7-bit).
  - row6 = ((scroll_y + raster_y) mod 1024) >> 3.
  - page = stride[7] & col7[6].
  - vram_address = {page, row6, col7[5:0]} + map_base_address (15-bit, wraps).
- Returned data:
  - Each accepted request pushes (layer, c) into a READ_LATENCY-deep tag shift pipeline.
  - map_data_valid, map_data_layer and map_data_column emerge aligned with vram_read_data.
- DRAIN and completion:
  - When the tag pipeline is empty, pulse line_done for one cycle and return to IDLE.
- line_start in FETCH or DRAIN is ignored, and overrun pulses in that cycle.
- Reset:
  - reset_n low at any time forces IDLE and clears the tag pipeline.
  - All outputs 0: vram_read_req, vram_address, map_data_valid, map_data_layer, map_data_column, busy, line_done, overrun.
  - map_data follows vram_read_data.

## Timing
- line_start is sampled in cycle 0; vram_read_req rises in cycle 1. Request outputs are registered.
- With N enabled layers and ready held high:
  - Requests occupy cycles 1..N*COLUMNS.
  - The last map_data_valid is in cycle N*COLUMNS+READ_LATENCY.
  - line_done is in cycle N*COLUMNS+READ_LATENCY+1.
- busy is high from cycle 1 through the line_done cycle inclusive, and low otherwise.
- No layers enabled: busy and line_done both high in cycle 1; no request is issued.
- A line_start in the same cycle as line_done is an overrun and is dropped.
- Throughput is one request per cycle; each ready-low cycle adds exactly one cycle to completion.

## Test plan
- Base case:
  - Stimulus: COLUMNS=4, layer 0 only, scroll 0/0, base 0x1000, stride 0x40, raster_y 17, ready=1.
  - Required: addresses 0x1080, 0x1081, 0x1082, 0x1083 in cycles 1..4; tags (0,0..3) in cycles 3..6; line_done in cycle 7.
- Horizontal wrap:
  - Stimulus: scroll_x_coarse 126, base 0, raster_y 0, stride 0x80.
  - Required: addresses 0x103E, 0x103F, 0x0000, 0x0001. Repeating with stride 0x40 gives 0x003E, 0x003F, 0x0000, 0x0001.
- Vertical wrap:
  - Stimulus: scroll_y 1020, raster_y 10, base 0.
  - Required: row 0; column-0 address 0x0000.
- Backpressure and layer skipping:
  - Stimulus: layers 0 and 2 enabled; ready alternates 1, 0.
  - Required: order L0c0, L2c0, L0c1, …; address stable across ready-low cycles; tags match; line_done in cycle 2*8+2+1 for COLUMNS=4.
- Overrun and empty line:
  - Stimulus: line_start during FETCH; separately, line_start with layer_enable=0.
  - Required: overrun pulses and the sequence is unchanged. The empty line gives busy and line_done in cycle 1 and no request.
- Reset mid-line:
  - Stimulus: reset_n low during FETCH with requests in flight.
  - Required: vram_read_req, busy and map_data_valid go 0 asynchronously. No stale valid after release. The next line_start fetches normally.

Source files
------------

// File: rtl/vdp_map_fetch_scheduler.sv
// vdp_map_fetch_scheduler
// Per-raster-line tilemap fetch sequencer. A line_start strobe snapshots the
// line's configuration and walks every enabled layer across COLUMNS coarse
// columns. The walk is column-major: within each column, enabled layers are
// visited in ascending order. Each (layer, column) pair becomes one map-entry
// read on a ready/valid VRAM request port.
// Each accepted read pushes its (layer, column) tag into a READ_LATENCY-deep
// shift pipeline. The tag therefore emerges aligned with the returned VRAM word.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   line_start            one-cycle strobe starting a line fetch
//   raster_y              line being prepared
//   layer_enable          per-layer enable
//   scroll_y              10 bits per layer
//   scroll_x_coarse       7 bits per layer
//   map_base_address      15 bits per layer (16-bit word address)
//   stride                8 bits per layer; bit 7 selects a 128-wide map
//   vram_read_req/_ready  request handshake
//   vram_address          request word address
//   vram_read_data        read data, READ_LATENCY cycles after acceptance
//   map_data*             returned entry with valid, layer and column tags
//   busy                  line fetch in progress
//   line_done             one-cycle pulse at line completion
//   overrun               line_start seen while busy (dropped)
module vdp_map_fetch_scheduler #(
  parameter int LAYERS       = 4,
  parameter int COLUMNS      = 64,
  parameter int READ_LATENCY = 2,
  localparam int LW          = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   line_start,
  input  logic [9:0]             raster_y,
  input  logic [LAYERS-1:0]      layer_enable,
  input  logic [10*LAYERS-1:0]   scroll_y,
  input  logic [7*LAYERS-1:0]    scroll_x_coarse,
  input  logic [15*LAYERS-1:0]   map_base_address,
  input  logic [8*LAYERS-1:0]    stride,
  output logic                   vram_read_req,
  output logic [14:0]            vram_address,
  input  logic                   vram_read_ready,
  input  logic [15:0]            vram_read_data,
  output logic [15:0]            map_data,
  output logic                   map_data_valid,
  output logic [LW-1:0]          map_data_layer,
  output logic [6:0]             map_data_column,
  output logic                   busy,
  output logic                   line_done,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);

  // Map-entry address: {page, row6, col6} offset added to the layer base.
  function automatic logic [14:0] map_addr(input logic [9:0] sy, input logic [9:0] ry,
                                           input logic [6:0] sx, input logic [6:0] col,
                                           input logic wide, input logic [14:0] base);
    logic [6:0] c7;
    logic [5:0] row6;
    c7   = sx + col;
    row6 = 6'((sy + ry) >> 3);
    map_addr = base + {2'b00, wide & c7[6], row6, c7[5:0]};
  endfunction

  // Lowest set index in an enable mask.
  function automatic logic [LW-1:0] lowest_en(input logic [LAYERS-1:0] en);
    lowest_en = '0;
    for (int l = LAYERS - 1; l >= 0; l--) begin
      if (en[l]) lowest_en = LW'(l);
    end
  endfunction

  state_t            state_q, state_d;
  logic [LW-1:0]     layer_q, layer_d;
  logic [6:0]        col_q, col_d;
  logic              req_q, req_d;
  logic [14:0]       addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              push_s, load_s;

  // Line configuration snapshot
  logic [9:0]        ry_q;
  logic [LAYERS-1:0] en_q;
  logic [9:0]        sy_q   [LAYERS];
  logic [6:0]        sx_q   [LAYERS];
  logic [14:0]       base_q [LAYERS];
  logic [LAYERS-1:0] wide_q;

  // Live configuration unpacked per layer
  logic [9:0]        live_sy_s   [LAYERS];
  logic [6:0]        live_sx_s   [LAYERS];
  logic [14:0]       live_base_s [LAYERS];
  logic [LAYERS-1:0] live_wide_s;
  logic [LW-1:0]     live_first_s;
  logic [LW-1:0]     first_q_s;
  logic              hi_found_s;
  logic [LW-1:0]     hi_layer_s;
  logic              drain_empty_s;
  logic              unused_stride_s;

  // Tag pipeline
  logic              tag_v_q [READ_LATENCY];
  logic [LW-1:0]     tag_l_q [READ_LATENCY];
  logic [6:0]        tag_c_q [READ_LATENCY];

  // Unpack live per-layer fields; only stride bit 7 carries meaning.
  always_comb begin
    unused_stride_s = 1'b0;
    for (int l = 0; l < LAYERS; l++) begin
      live_sy_s[l]    = scroll_y[10*l +: 10];
      live_sx_s[l]    = scroll_x_coarse[7*l +: 7];
      live_base_s[l]  = map_base_address[15*l +: 15];
      live_wide_s[l]  = stride[8*l + 7];
      unused_stride_s = unused_stride_s ^ (^stride[8*l +: 7]);
    end
    live_first_s = lowest_en(layer_enable);
    first_q_s    = lowest_en(en_q);
  end

  // Next enabled layer above the current one within the same column.
  always_comb begin
    hi_found_s = 1'b0;
    hi_layer_s = '0;
    for (int l = LAYERS - 1; l >= 0; l--) begin
      if (en_q[l] && (l > int'(layer_q))) begin
        hi_found_s = 1'b1;
        hi_layer_s = LW'(l);
      end
    end
  end

  // Pipeline will hold nothing after this edge (nothing is pushed in DRAIN).
  always_comb begin
    drain_empty_s = 1'b1;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      if (tag_v_q[i]) drain_empty_s = 1'b0;
    end
  end

  // Sequencer next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    col_d   = col_q;
    req_d   = req_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    push_s  = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_start) begin
          load_s = 1'b1;
          busy_d = 1'b1;
          if (|layer_enable) begin
            state_d = ST_FETCH;
            layer_d = live_first_s;
            col_d   = 7'd0;
            req_d   = 1'b1;
            // Snapshot is not loaded yet, so the first address uses live inputs.
            addr_d  = map_addr(live_sy_s[live_first_s], raster_y, live_sx_s[live_first_s],
                               7'd0, live_wide_s[live_first_s], live_base_s[live_first_s]);
          end else begin
            // Empty line: busy and line_done together, no request.
            state_d = ST_DRAIN;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (req_q && vram_read_ready) begin
          push_s = 1'b1;
          if (hi_found_s) begin
            layer_d = hi_layer_s;
            addr_d  = map_addr(sy_q[hi_layer_s], ry_q, sx_q[hi_layer_s], col_q,
                               wide_q[hi_layer_s], base_q[hi_layer_s]);
          end else if (col_q == LAST_COL) begin
            req_d   = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            col_d   = col_q + 7'd1;
            layer_d = first_q_s;
            addr_d  = map_addr(sy_q[first_q_s], ry_q, sx_q[first_q_s], col_q + 7'd1,
                               wide_q[first_q_s], base_q[first_q_s]);
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        // line_done is held in DRAIN for its single cycle so busy covers it.
        if (done_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (drain_empty_s) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered request/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      col_q   <= 7'd0;
      req_q   <= 1'b0;
      addr_q  <= 15'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      col_q   <= col_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Line configuration snapshot, captured only at line start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ry_q   <= 10'd0;
      en_q   <= '0;
      wide_q <= '0;
      for (int l = 0; l < LAYERS; l++) begin
        sy_q[l]   <= 10'd0;
        sx_q[l]   <= 7'd0;
        base_q[l] <= 15'd0;
      end
    end else if (load_s) begin
      ry_q   <= raster_y;
      en_q   <= layer_enable;
      wide_q <= live_wide_s;
      for (int l = 0; l < LAYERS; l++) begin
        sy_q[l]   <= live_sy_s[l];
        sx_q[l]   <= live_sx_s[l];
        base_q[l] <= live_base_s[l];
      end
    end
  end

  // Tag shift pipeline; empty stages carry zero tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_l_q[i] <= '0;
        tag_c_q[i] <= 7'd0;
      end
    end else begin
      tag_v_q[0] <= push_s;
      tag_l_q[0] <= push_s ? layer_q : '0;
      tag_c_q[0] <= push_s ? col_q : 7'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
        tag_c_q[i] <= tag_c_q[i-1];
      end
    end
  end

  assign vram_read_req   = req_q;
  assign vram_address    = addr_q;
  assign busy            = busy_q;
  assign line_done       = done_q;
  // Reported in the same cycle as the dropped strobe.
  assign overrun         = line_start & (state_q != ST_IDLE);
  assign map_data        = vram_read_data;
  assign map_data_valid  = tag_v_q[READ_LATENCY-1];
  assign map_data_layer  = tag_l_q[READ_LATENCY-1];
  assign map_data_column = tag_c_q[READ_LATENCY-1];

endmodule

// File: tb/tb_vdp_map_fetch_scheduler.sv
module tb_vdp_map_fetch_scheduler;
  localparam int L  = 4;
  localparam int C  = 4;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            line_start = 1'b0;
  logic [9:0]      raster_y = 10'd0;
  logic [L-1:0]    layer_enable = '0;
  logic [10*L-1:0] scroll_y = '0;
  logic [7*L-1:0]  scroll_x_coarse = '0;
  logic [15*L-1:0] map_base_address = '0;
  logic [8*L-1:0]  stride = '0;
  logic            vram_read_req;
  logic [14:0]     vram_address;
  logic            vram_read_ready = 1'b0;
  logic [15:0]     vram_read_data = 16'd0;
  logic [15:0]     map_data;
  logic            map_data_valid;
  logic [1:0]      map_data_layer;
  logic [6:0]      map_data_column;
  logic            busy, line_done, overrun;

  vdp_map_fetch_scheduler #(.LAYERS(L), .COLUMNS(C), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .raster_y(raster_y),
    .layer_enable(layer_enable), .scroll_y(scroll_y), .scroll_x_coarse(scroll_x_coarse),
    .map_base_address(map_base_address), .stride(stride),
    .vram_read_req(vram_read_req), .vram_address(vram_address),
    .vram_read_ready(vram_read_ready), .vram_read_data(vram_read_data),
    .map_data(map_data), .map_data_valid(map_data_valid),
    .map_data_layer(map_data_layer), .map_data_column(map_data_column),
    .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [L-1:0] cfg_en;
  logic [9:0]   cfg_ry;
  logic [9:0]   cfg_sy [L];
  logic [6:0]   cfg_sx [L];
  logic [14:0]  cfg_base [L];
  logic [7:0]   cfg_stride [L];

  int obs_a[$];
  int obs_l[$];
  int obs_done;
  int obs_first_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [L-1:0] en, input logic [9:0] ry, input logic [9:0] sy,
                         input logic [6:0] sx, input logic [14:0] base, input logic [7:0] st);
    cfg_en = en;
    cfg_ry = ry;
    for (int l = 0; l < L; l++) begin
      cfg_sy[l] = sy; cfg_sx[l] = sx; cfg_base[l] = base; cfg_stride[l] = st;
    end
  endtask

  task automatic apply_cfg();
    raster_y = cfg_ry;
    layer_enable = cfg_en;
    for (int l = 0; l < L; l++) begin
      scroll_y[10*l +: 10]         = cfg_sy[l];
      scroll_x_coarse[7*l +: 7]    = cfg_sx[l];
      map_base_address[15*l +: 15] = cfg_base[l];
      stride[8*l +: 8]             = cfg_stride[l];
    end
  endtask

  task automatic scramble_inputs();
    raster_y = 10'($urandom);
    layer_enable = L'($urandom);
    scroll_y = {$urandom, $urandom};
    scroll_x_coarse = 28'($urandom);
    map_base_address = {$urandom, $urandom};
    stride = $urandom;
  endtask

  // One line: reference model is an ordered list of expected reads, plus a
  // queue of (due cycle, tag) for returned data. Cycle 0 = line_start cycle.
  task automatic run_line(input int mode, input int ovr_cyc, input bit scramble);
    int exp_a[$], exp_l[$], exp_c[$];
    int due[$], dl[$], dc[$];
    int idx, t, done_cyc, n, col7, row, page, junk;
    bit rdy, v_exp, busy_exp, req_exp;
    for (int c = 0; c < C; c++) begin
      for (int l = 0; l < L; l++) begin
        if (cfg_en[l]) begin
          col7 = (int'(cfg_sx[l]) + c) % 128;
          row  = ((int'(cfg_sy[l]) + int'(cfg_ry)) % 1024) / 8 % 64;
          page = (cfg_stride[l][7] && col7 >= 64) ? 1 : 0;
          exp_a.push_back((int'(cfg_base[l]) + page * 4096 + row * 64 + col7 % 64) % 32768);
          exp_l.push_back(l);
          exp_c.push_back(c);
        end
      end
    end
    n = exp_a.size();
    obs_a.delete(); obs_l.delete(); obs_done = -1; obs_first_valid = -1;
    idx = 0;
    done_cyc = (n == 0) ? 1 : -1;
    @(posedge clk); #1;
    t = 0;
    apply_cfg();
    line_start = 1'b1;
    vram_read_ready = 1'b1;
    vram_read_data = 16'($urandom);
    while (t <= 1000) begin
      @(negedge clk);
      rdy = vram_read_ready;
      busy_exp = (t >= 1) && (done_cyc < 0 || t <= done_cyc);
      req_exp = (t >= 1) && (idx < n);
      check("busy", busy, busy_exp);
      check("overrun", overrun, line_start && busy_exp);
      check("line_done", line_done, t == done_cyc);
      check("req", vram_read_req, req_exp);
      if (req_exp) check("addr", vram_address, exp_a[idx]);
      check("map_data", map_data, vram_read_data);
      v_exp = (due.size() > 0) && (due[0] == t);
      check("valid", map_data_valid, v_exp);
      if (v_exp) begin
        check("tag_layer", map_data_layer, dl[0]);
        check("tag_col", map_data_column, dc[0]);
        junk = due.pop_front(); junk = dl.pop_front(); junk = dc.pop_front();
      end
      if (vram_read_req && vram_read_ready) obs_a.push_back(int'(vram_address));
      if (map_data_valid) begin
        obs_l.push_back(int'(map_data_layer));
        if (obs_first_valid < 0) obs_first_valid = t;
      end
      if (line_done && obs_done < 0) obs_done = t;
      if (req_exp && rdy) begin
        due.push_back(t + RL); dl.push_back(exp_l[idx]); dc.push_back(exp_c[idx]);
        idx++;
        if (idx == n) done_cyc = t + RL + 1;
      end
      if (done_cyc >= 0 && t == done_cyc + 1) break;
      @(posedge clk); #1;
      t++;
      line_start = (t == ovr_cyc);
      if (scramble) scramble_inputs();
      vram_read_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      vram_read_data = 16'($urandom);
    end
    line_start = 1'b0;
    check("done_cycle", obs_done, done_cyc);
  endtask

  initial begin
    int ovr;
    #12;
    check("rst_req", vram_read_req, 1'b0);
    check("rst_addr", vram_address, 15'd0);
    check("rst_valid", map_data_valid, 1'b0);
    check("rst_layer", map_data_layer, 2'd0);
    check("rst_col", map_data_column, 7'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", line_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_map_data", map_data, vram_read_data);
    @(negedge clk); reset_n = 1'b1;

    // Base case
    set_all(4'b0001, 10'd17, 10'd0, 7'd0, 15'h1000, 8'h40);
    run_line(0, -1, 1'b0);
    check("base_n", obs_a.size(), 4);
    for (int i = 0; i < 4 && i < obs_a.size(); i++) check("base_addr", obs_a[i], 32'h1080 + i);
    check("base_first_valid", obs_first_valid, 3);
    check("base_done", obs_done, 7);

    // Horizontal wrap, wide then narrow map
    set_all(4'b0001, 10'd0, 10'd0, 7'd126, 15'h0000, 8'h80);
    run_line(0, -1, 1'b0);
    check("hwrap_n", obs_a.size(), 4);
    if (obs_a.size() == 4) begin
      check("hwrap_a0", obs_a[0], 32'h103E); check("hwrap_a1", obs_a[1], 32'h103F);
      check("hwrap_a2", obs_a[2], 32'h0000); check("hwrap_a3", obs_a[3], 32'h0001);
    end
    set_all(4'b0001, 10'd0, 10'd0, 7'd126, 15'h0000, 8'h40);
    run_line(0, -1, 1'b0);
    check("hwrap40_n", obs_a.size(), 4);
    if (obs_a.size() == 4) begin
      check("hwrap40_a0", obs_a[0], 32'h003E); check("hwrap40_a1", obs_a[1], 32'h003F);
      check("hwrap40_a2", obs_a[2], 32'h0000);
    end

    // Vertical wrap
    set_all(4'b0001, 10'd10, 10'd1020, 7'd0, 15'h0000, 8'h40);
    run_line(0, -1, 1'b0);
    if (obs_a.size() > 0) check("vwrap_a0", obs_a[0], 32'h0000);
    else check("vwrap_n", obs_a.size(), 4);

    // Backpressure with layers 0 and 2
    set_all(4'b0101, 10'd33, 10'd5, 7'd3, 15'h0400, 8'h40);
    cfg_base[2] = 15'h2000;
    run_line(1, -1, 1'b0);
    check("bp_done", obs_done, 19);
    check("bp_nvalid", obs_l.size(), 8);
    for (int i = 0; i < 4 && i < obs_l.size(); i++) check("bp_order", obs_l[i], (i % 2) * 2);

    // Overrun mid-FETCH and in the line_done cycle
    set_all(4'b0011, 10'd17, 10'd0, 7'd0, 15'h1000, 8'h40);
    run_line(0, 2, 1'b0);
    run_line(0, 2 * C + RL + 1, 1'b0);

    // Empty line
    set_all(4'b0000, 10'd17, 10'd0, 7'd0, 15'h1000, 8'h40);
    run_line(0, 1, 1'b0);
    check("empty_done", obs_done, 1);
    check("empty_nreq", obs_a.size(), 0);

    // Reset mid-line with requests in flight
    set_all(4'b1111, 10'd40, 10'd8, 7'd9, 15'h0123, 8'h80);
    @(posedge clk); #1;
    apply_cfg(); line_start = 1'b1; vram_read_ready = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    check("mid_rst_req", vram_read_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", map_data_valid, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", map_data_valid, 1'b0);
      check("post_rst_req", vram_read_req, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    run_line(0, -1, 1'b0);

    // Randomized lines with backpressure and inputs changing mid-line
    repeat (12) begin
      cfg_en = 4'($urandom);
      cfg_ry = 10'($urandom);
      for (int l = 0; l < L; l++) begin
        cfg_sy[l] = 10'($urandom); cfg_sx[l] = 7'($urandom);
        cfg_base[l] = 15'($urandom); cfg_stride[l] = 8'($urandom);
      end
      ovr = -1;
      if ($urandom_range(0, 1) == 1) ovr = (cfg_en == 4'b0000) ? 1 : int'($urandom_range(1, 3));
      run_line(2, ovr, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
